// File: rtl/id_pkg.sv
// Shared types for the decode stage: decoded control word, branch kinds,
// and the exception vector used when a redirect is forced by an exception.
package id_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LEZ  = 3'd3,
        BR_GTZ  = 3'd4,
        BR_LTZ  = 3'd5,
        BR_GEZ  = 3'd6
    } br_type_e;

    // Byte address of the exception handler; the stage emits it as a word address.
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

    typedef struct packed {
        logic       extop;
        logic       exsign;
        logic [2:0] branch_type;
        logic       jmp;
        logic       npc_from_gpr;
        logic       npc_from_epc;
        logic       exl_set;
        logic       uses_rs;
        logic       uses_rt;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_we;
        logic       mem_re;
        logic       reg_we;
        logic [1:0] reg_dst;
    } id_ctrl_t;

    // Instructions that consume a register value already in ID (compare or jump-register).
    function automatic logic reads_gpr_in_id(input id_ctrl_t c);
        return (c.branch_type != 3'd0) || c.npc_from_gpr;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 32-entry register file, two combinational reads and one synchronous write.
// Register 0 is hard-wired to zero on both the write and read sides.
module id_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: operand read with forwarding, immediate extension,
// branch/jump resolution, load-use interlock and a registered hand-off to EX.
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NFWD        = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-3:0]        in_pcp1,
    input  logic [31:0]            in_instr,
    input  id_ctrl_t               in_ctrl,
    input  logic                   flush,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*5-1:0]      fwd_rw,
    input  logic [NFWD*XLEN-1:0]   fwd_wd,
    input  logic                   ex_we,
    input  logic                   ex_load,
    input  logic [4:0]             ex_rw,
    input  logic [XLEN-3:0]        epc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-3:0]        out_pcp1,
    output logic [31:0]            out_instr,
    output logic [XLEN-1:0]        out_rd1,
    output logic [XLEN-1:0]        out_rd2,
    output logic [XLEN-1:0]        out_ext,
    output id_ctrl_t               out_ctrl,
    output logic [XLEN-3:0]        jpc,
    output logic                   jpc_avail,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [XLEN-1:0] EXC_VEC = XLEN'(EXC_VECTOR);

    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [15:0]     imm;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext;
    logic            br_taken;
    logic            redirect;
    logic            hazard;
    logic            accept;
    logic            rs_hit;
    logic            rt_hit;

    logic                   out_valid_q, out_valid_d;
    logic [XLEN-3:0]        out_pcp1_q,  out_pcp1_d;
    logic [31:0]            out_instr_q, out_instr_d;
    logic [XLEN-1:0]        out_rd1_q,   out_rd1_d;
    logic [XLEN-1:0]        out_rd2_q,   out_rd2_d;
    logic [XLEN-1:0]        out_ext_q,   out_ext_d;
    id_ctrl_t               out_ctrl_q,  out_ctrl_d;
    logic [STALL_CNT_W-1:0] stall_q,     stall_d;

    assign rs  = in_instr[25:21];
    assign rt  = in_instr[20:16];
    assign imm = in_instr[15:0];

    id_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .we_i  (fwd_we[NFWD-1]),
        .wa_i  (fwd_rw[(NFWD-1)*5 +: 5]),
        .wd_i  (fwd_wd[(NFWD-1)*XLEN +: XLEN]),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2)
    );

    // Walk from oldest to newest so the lowest-index matching channel wins.
    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_rw[i*5 +: 5] != 5'd0)) begin
                if (fwd_rw[i*5 +: 5] == rs) begin
                    rd1 = fwd_wd[i*XLEN +: XLEN];
                end
                if (fwd_rw[i*5 +: 5] == rt) begin
                    rd2 = fwd_wd[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        if (in_ctrl.extop) begin
            ext = XLEN'(imm) << 16;
        end else if (in_ctrl.exsign) begin
            ext = XLEN'($signed(imm));
        end else begin
            ext = XLEN'(imm);
        end
    end

    always_comb begin
        case (in_ctrl.branch_type)
            BR_EQ:   br_taken = (rd1 == rd2);
            BR_NE:   br_taken = (rd1 != rd2);
            BR_LEZ:  br_taken = rd1[XLEN-1] || (rd1 == '0);
            BR_GTZ:  br_taken = !rd1[XLEN-1] && (rd1 != '0);
            BR_LTZ:  br_taken = rd1[XLEN-1];
            BR_GEZ:  br_taken = !rd1[XLEN-1];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        if (in_ctrl.exl_set) begin
            jpc = EXC_VEC[XLEN-1:2];
        end else if (in_ctrl.npc_from_epc) begin
            jpc = epc;
        end else if (in_ctrl.npc_from_gpr) begin
            jpc = rd1[XLEN-1:2];
        end else if (in_ctrl.jmp) begin
            jpc = {in_pcp1[XLEN-3 -: (XLEN-28)], in_instr[25:0]};
        end else begin
            jpc = in_pcp1 + (XLEN-2)'($signed(imm));
        end
    end

    assign redirect = in_ctrl.exl_set || in_ctrl.npc_from_epc || in_ctrl.npc_from_gpr
                    || in_ctrl.jmp || br_taken;

    // Loads stall any consumer; other EX writers only stall consumers that resolve in ID.
    assign rs_hit = in_ctrl.uses_rs && (rs == ex_rw);
    assign rt_hit = in_ctrl.uses_rt && (rt == ex_rw);
    assign hazard = in_valid && (ex_rw != 5'd0)
                  && ((ex_load && (rs_hit || rt_hit))
                      || (ex_we && reads_gpr_in_id(in_ctrl) && (rs_hit || rt_hit)));

    assign in_ready  = !hazard && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign jpc_avail = accept && !flush && redirect;

    // A flush drops the valid bit and control but leaves stale data in place.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pcp1_d  = out_pcp1_q;
        out_instr_d = out_instr_q;
        out_rd1_d   = out_rd1_q;
        out_rd2_d   = out_rd2_q;
        out_ext_d   = out_ext_q;
        out_ctrl_d  = out_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_pcp1_d  = in_pcp1;
            out_instr_d = in_instr;
            out_rd1_d   = rd1;
            out_rd2_d   = rd2;
            out_ext_d   = ext;
            out_ctrl_d  = in_ctrl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && !flush && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pcp1_q  <= '0;
            out_instr_q <= '0;
            out_rd1_q   <= '0;
            out_rd2_q   <= '0;
            out_ext_q   <= '0;
            out_ctrl_q  <= '0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pcp1_q  <= out_pcp1_d;
            out_instr_q <= out_instr_d;
            out_rd1_q   <= out_rd1_d;
            out_rd2_q   <= out_rd2_d;
            out_ext_q   <= out_ext_d;
            out_ctrl_q  <= out_ctrl_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pcp1  = out_pcp1_q;
    assign out_instr = out_instr_q;
    assign out_rd1   = out_rd1_q;
    assign out_rd2   = out_rd2_q;
    assign out_ext   = out_ext_q;
    assign out_ctrl  = out_ctrl_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: branches, forwarding, interlock, backpressure,
// flush and stall-counter saturation, each with hand-computed expectations.
module tb_id_stage;
    import id_pkg::*;

    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int SW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-3:0]   in_pcp1;
    logic [31:0]       in_instr;
    id_ctrl_t          in_ctrl;
    logic              flush;
    logic [NFWD-1:0]   fwd_we;
    logic [NFWD*5-1:0] fwd_rw;
    logic [NFWD*XLEN-1:0] fwd_wd;
    logic              ex_we;
    logic              ex_load;
    logic [4:0]        ex_rw;
    logic [XLEN-3:0]   epc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-3:0]   out_pcp1;
    logic [31:0]       out_instr;
    logic [XLEN-1:0]   out_rd1;
    logic [XLEN-1:0]   out_rd2;
    logic [XLEN-1:0]   out_ext;
    id_ctrl_t          out_ctrl;
    logic [XLEN-3:0]   jpc;
    logic              jpc_avail;
    logic [SW-1:0]     stall_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    id_stage #(
        .XLEN        (XLEN),
        .NFWD        (NFWD),
        .STALL_CNT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pcp1   (in_pcp1),
        .in_instr  (in_instr),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .fwd_we    (fwd_we),
        .fwd_rw    (fwd_rw),
        .fwd_wd    (fwd_wd),
        .ex_we     (ex_we),
        .ex_load   (ex_load),
        .ex_rw     (ex_rw),
        .epc       (epc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pcp1  (out_pcp1),
        .out_instr (out_instr),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_ext   (out_ext),
        .out_ctrl  (out_ctrl),
        .jpc       (jpc),
        .jpc_avail (jpc_avail),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [XLEN-3:0] pcp1,
                                 input logic [31:0] instr, input id_ctrl_t ctrl);
        in_valid = valid;
        in_pcp1  = pcp1;
        in_instr = instr;
        in_ctrl  = ctrl;
        #1;
    endtask

    id_ctrl_t    c;
    logic [31:0] instrA;
    logic [31:0] instrB;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pcp1 = '0; in_instr = '0; in_ctrl = '0;
        flush = 1'b0; fwd_we = '0; fwd_rw = '0; fwd_wd = '0;
        ex_we = 1'b0; ex_load = 1'b0; ex_rw = '0; epc = '0; out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_ctrl",  64'(out_ctrl),  64'(0));
        checkOutput("rst_out_rd1",   64'(out_rd1),   64'(0));
        checkOutput("rst_stall",     64'(stall_cnt), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready",  64'(in_ready),  64'(1));

        // Load r1 = 7 and r2 = 7 through the oldest channel
        fwd_we = 2'b10; fwd_rw = {5'd1, 5'd0}; fwd_wd = {32'd7, 32'd0};
        tick();
        fwd_rw = {5'd2, 5'd0};
        tick();
        fwd_we = '0;

        c = '0; c.branch_type = BR_EQ; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.exsign = 1'b1;
        applyStimulus(1'b1, 30'h100, {6'h04, 5'd1, 5'd2, 16'hFFFE}, c);
        checkOutput("beq_jpc",   64'(jpc),       64'(30'h0FE));
        checkOutput("beq_avail", 64'(jpc_avail), 64'(1));
        tick();
        checkOutput("beq_out_valid", 64'(out_valid), 64'(1));
        checkOutput("beq_out_rd1",   64'(out_rd1),   64'(7));
        checkOutput("beq_out_rd2",   64'(out_rd2),   64'(7));
        checkOutput("beq_out_pcp1",  64'(out_pcp1),  64'(30'h100));
        checkOutput("beq_out_ext",   64'(out_ext),   64'(32'hFFFF_FFFE));
        checkOutput("beq_out_ctrl",  64'(out_ctrl),  64'(c));

        c.branch_type = BR_NE; c.exsign = 1'b0;
        applyStimulus(1'b1, 30'h100, {6'h05, 5'd1, 5'd2, 16'hFFFE}, c);
        checkOutput("bne_avail", 64'(jpc_avail), 64'(0));
        c.branch_type = BR_GTZ; applyStimulus(1'b1, 30'h100, in_instr, c);
        checkOutput("bgtz_avail", 64'(jpc_avail), 64'(1));
        c.branch_type = BR_LTZ; applyStimulus(1'b1, 30'h100, in_instr, c);
        checkOutput("bltz_avail", 64'(jpc_avail), 64'(0));
        c.branch_type = BR_LEZ; applyStimulus(1'b1, 30'h100, in_instr, c);
        checkOutput("blez_avail", 64'(jpc_avail), 64'(0));
        c.branch_type = BR_GEZ; applyStimulus(1'b1, 30'h100, in_instr, c);
        checkOutput("bgez_avail", 64'(jpc_avail), 64'(1));
        c.branch_type = 3'd7; applyStimulus(1'b1, 30'h100, in_instr, c);
        checkOutput("bunk_avail", 64'(jpc_avail), 64'(0));
        tick();
        checkOutput("bne_out_ext", 64'(out_ext), 64'(32'h0000_FFFE));

        c = '0; c.extop = 1'b1;
        applyStimulus(1'b1, 30'h104, {6'h0F, 5'd0, 5'd4, 16'h1234}, c);
        tick();
        checkOutput("lui_out_ext", 64'(out_ext), 64'(32'h1234_0000));

        epc = 30'h1234;
        c = '0; c.npc_from_epc = 1'b1;
        applyStimulus(1'b1, 30'h108, 32'h4200_0018, c);
        checkOutput("eret_jpc",   64'(jpc),       64'(30'h1234));
        checkOutput("eret_avail", 64'(jpc_avail), 64'(1));
        c.exl_set = 1'b1;
        applyStimulus(1'b1, 30'h108, 32'h4200_0018, c);
        checkOutput("exc_jpc", 64'(jpc), 64'(30'h2000_0060));

        // Jump-register whose source comes from the newest channel
        fwd_we = 2'b01; fwd_rw = {5'd0, 5'd1}; fwd_wd = {32'd0, 32'h400};
        c = '0; c.npc_from_gpr = 1'b1; c.uses_rs = 1'b1;
        applyStimulus(1'b1, 30'h10C, {6'h00, 5'd1, 5'd0, 16'h0008}, c);
        checkOutput("jr_jpc", 64'(jpc), 64'(30'h100));
        tick();
        fwd_we = '0;

        fwd_we = 2'b11; fwd_rw = {5'd3, 5'd3}; fwd_wd = {32'h22, 32'h11};
        c = '0; c.uses_rs = 1'b1;
        applyStimulus(1'b1, 30'h110, {6'h00, 5'd3, 5'd0, 16'h0}, c);
        tick();
        checkOutput("fwd_prio_rd1", 64'(out_rd1), 64'(32'h11));
        fwd_we = '0;
        applyStimulus(1'b1, 30'h114, {6'h00, 5'd3, 5'd0, 16'h0}, c);
        tick();
        checkOutput("rf_r3_rd1", 64'(out_rd1), 64'(32'h22));

        fwd_we = 2'b10; fwd_rw = {5'd0, 5'd0}; fwd_wd = {32'h55, 32'h0};
        applyStimulus(1'b1, 30'h118, {6'h00, 5'd0, 5'd0, 16'h0}, c);
        tick();
        checkOutput("r0_fwd_rd1", 64'(out_rd1), 64'(0));
        fwd_we = '0;

        ex_load = 1'b1; ex_rw = 5'd5;
        applyStimulus(1'b1, 30'h200, {6'h00, 5'd5, 5'd0, 16'h0}, c);
        checkOutput("lu_in_ready", 64'(in_ready),  64'(0));
        checkOutput("lu_stall0",   64'(stall_cnt), 64'(0));
        tick();
        checkOutput("lu_stall1",     64'(stall_cnt), 64'(1));
        checkOutput("lu_out_valid0", 64'(out_valid), 64'(0));
        ex_load = 1'b0;
        #1;
        checkOutput("lu_in_ready1", 64'(in_ready), 64'(1));
        tick();
        checkOutput("lu_out_valid1", 64'(out_valid), 64'(1));
        checkOutput("lu_out_instr",  64'(out_instr), 64'({6'h00, 5'd5, 5'd0, 16'h0}));
        checkOutput("lu_stall_hold", 64'(stall_cnt), 64'(1));

        ex_we = 1'b1; ex_rw = 5'd1;
        c = '0; c.branch_type = BR_EQ; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
        applyStimulus(1'b1, 30'h204, {6'h04, 5'd1, 5'd2, 16'h0}, c);
        checkOutput("br_hazard_ready", 64'(in_ready), 64'(0));
        c = '0; c.uses_rs = 1'b1;
        applyStimulus(1'b1, 30'h204, {6'h00, 5'd1, 5'd2, 16'h0}, c);
        checkOutput("alu_no_hazard", 64'(in_ready), 64'(1));
        ex_we = 1'b0; ex_rw = 5'd0;

        instrA = 32'h0022_1820;
        instrB = 32'h0043_2020;
        c = '0; c.alu_op = 4'd3; c.reg_we = 1'b1;
        applyStimulus(1'b1, 30'h300, instrA, c);
        tick();
        out_ready = 1'b0;
        applyStimulus(1'b1, 30'h304, instrB, c);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            tick();
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp_out_instr", 64'(out_instr), 64'(instrA));
            checkOutput("bp_out_pcp1",  64'(out_pcp1),  64'(30'h300));
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(in_ready), 64'(1));
        tick();
        checkOutput("bp_next_instr", 64'(out_instr), 64'(instrB));
        checkOutput("bp_next_pcp1",  64'(out_pcp1),  64'(30'h304));
        in_valid = 1'b0;
        tick();
        checkOutput("idle_out_valid", 64'(out_valid), 64'(0));

        applyStimulus(1'b1, 30'h308, instrA, c);
        tick();
        c = '0; c.jmp = 1'b1;
        applyStimulus(1'b1, 30'h3000_0100, {6'h02, 26'h40}, c);
        checkOutput("j_jpc",   64'(jpc),       64'(30'h3000_0040));
        checkOutput("j_avail", 64'(jpc_avail), 64'(1));
        flush = 1'b1;
        #1;
        checkOutput("flush_j_avail", 64'(jpc_avail), 64'(0));
        tick();
        checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
        checkOutput("flush_out_ctrl",  64'(out_ctrl),  64'(0));

        // Hazard under flush must not count
        ex_load = 1'b1; ex_rw = 5'd5;
        c = '0; c.uses_rs = 1'b1;
        applyStimulus(1'b1, 30'h400, {6'h00, 5'd5, 5'd0, 16'h0}, c);
        tick();
        checkOutput("flush_stall_hold", 64'(stall_cnt), 64'(1));
        flush = 1'b0;
        #1;
        repeat (13) tick();
        checkOutput("stall_14", 64'(stall_cnt), 64'(14));
        repeat (7) tick();
        checkOutput("stall_sat", 64'(stall_cnt), 64'(15));

        rst = 1'b1;
        tick();
        rst = 1'b0; ex_load = 1'b0; ex_rw = 5'd0;
        #1;
        checkOutput("rst2_stall",     64'(stall_cnt), 64'(0));
        checkOutput("rst2_out_valid", 64'(out_valid), 64'(0));
        applyStimulus(1'b1, 30'h500, {6'h00, 5'd3, 5'd0, 16'h0}, c);
        tick();
        checkOutput("rst2_r3_rd1", 64'(out_rd1), 64'(0));
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
